// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the IF/MEM pipeline stages, the memory port arbiter
// and the unified external memory bus.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        if_stall;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_stall;
  logic        ext_cyc;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic [31:0] ext_rdata;
  logic        ext_ack;
  logic        bus_error;

  modport slave (
    input  if_req, if_addr, mem_ren, mem_wen, mem_addr, mem_wdata, ext_rdata, ext_ack,
    output if_rdata, if_ready, if_stall, mem_rdata, mem_ready, mem_stall,
           ext_cyc, ext_we, ext_addr, ext_wdata, bus_error
  );

  modport master (
    output if_req, if_addr, mem_ren, mem_wen, mem_addr, mem_wdata, ext_rdata, ext_ack,
    input  if_rdata, if_ready, if_stall, mem_rdata, mem_ready, mem_stall,
           ext_cyc, ext_we, ext_addr, ext_wdata, bus_error
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and data access,
// with data priority bounded by a fairness counter and a per-access ack timeout.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
  input logic         clk,
  input logic         rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, DONE} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_tmo;
  logic [1:0]  r_fair;
  logic        r_ext_cyc;
  logic        r_ext_we;
  logic [31:0] r_ext_addr;
  logic [31:0] r_ext_wdata;
  logic [31:0] r_if_rdata;
  logic [31:0] r_mem_rdata;
  logic        r_if_ready;
  logic        r_mem_ready;
  logic        r_bus_error;

  logic        w_data_req;
  logic        w_wait;
  logic        w_ack;
  logic        w_tmo;
  logic        w_grant_data;
  logic        w_grant_fetch;
  logic [31:0] w_result;

  assign w_data_req = bus.mem_ren | bus.mem_wen;
  assign w_wait     = (r_state == FETCH) || (r_state == DATA);
  assign w_ack      = w_wait && bus.ext_ack;
  assign w_tmo      = w_wait && !bus.ext_ack && (r_tmo == TMO_LAST);
  assign w_result   = w_tmo ? ERR_DATA : (r_ext_we ? 32'd0 : bus.ext_rdata);

  // Fetch only overtakes a pending data request after two data grants that starved it.
  always_comb begin
    w_next        = r_state;
    w_grant_data  = 1'b0;
    w_grant_fetch = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_data_req && !((r_fair == 2'd2) && bus.if_req)) begin
          w_grant_data = 1'b1;
          w_next       = DATA;
        end else if (bus.if_req) begin
          w_grant_fetch = 1'b1;
          w_next        = FETCH;
        end
      end
      FETCH, DATA: begin
        if (w_ack || w_tmo) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo       <= 8'd0;
      r_fair      <= 2'd0;
      r_ext_cyc   <= 1'b0;
      r_ext_we    <= 1'b0;
      r_ext_addr  <= 32'd0;
      r_ext_wdata <= 32'd0;
      r_if_rdata  <= 32'd0;
      r_mem_rdata <= 32'd0;
      r_if_ready  <= 1'b0;
      r_mem_ready <= 1'b0;
      r_bus_error <= 1'b0;
    end else begin
      r_if_ready  <= 1'b0;
      r_mem_ready <= 1'b0;
      if (w_grant_data || w_grant_fetch) begin
        r_ext_cyc   <= 1'b1;
        r_tmo       <= 8'd0;
        r_ext_we    <= w_grant_data & bus.mem_wen;
        r_ext_addr  <= w_grant_data ? bus.mem_addr : bus.if_addr;
        r_ext_wdata <= w_grant_data ? bus.mem_wdata : 32'd0;
      end
      if (w_grant_data && bus.if_req && (r_fair != 2'd2)) r_fair <= r_fair + 2'd1;
      if (w_grant_fetch) r_fair <= 2'd0;
      if (w_wait && !w_ack && !w_tmo) r_tmo <= r_tmo + 8'd1;
      // A withdrawn requester still lets the bus access finish; only its ready is suppressed.
      if (w_ack || w_tmo) begin
        r_ext_cyc <= 1'b0;
        r_ext_we  <= 1'b0;
        r_tmo     <= 8'd0;
        if (r_state == DATA) begin
          r_mem_rdata <= w_result;
          r_mem_ready <= w_data_req;
        end else begin
          r_if_rdata <= w_result;
          r_if_ready <= bus.if_req;
        end
        if (w_tmo) r_bus_error <= 1'b1;
      end
    end
  end

  assign bus.ext_cyc   = r_ext_cyc;
  assign bus.ext_we    = r_ext_we;
  assign bus.ext_addr  = r_ext_addr;
  assign bus.ext_wdata = r_ext_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.mem_rdata = r_mem_rdata;
  assign bus.if_ready  = r_if_ready;
  assign bus.mem_ready = r_mem_ready;
  assign bus.bus_error = r_bus_error;
  assign bus.if_stall  = bus.if_req & ~r_if_ready;
  assign bus.mem_stall = w_data_req & ~r_mem_ready;

endmodule
